wave_voice_sequencer: RTL

- Initiator side of the wavetable lookup interface; the lookup block sits in front of it.
- Owns 16 per-voice phase accumulators. On each audio sample tick it walks the voices round-robin, one per cycle, presenting instrument number and wave pointer to the lookup.
- Collects the returned 8-bit samples and produces one signed 12-bit mixed sample per tick.
- Sits between the MIDI/voice-allocation logic (config writes) and the DAC/output stage (mix_out).

---
 rtl/wave_voice_sequencer.sv | 163 ++++++++++++++++
 1 files changed

// File: rtl/wave_voice_sequencer.sv
// rtl/wave_voice_sequencer.sv - round-robin wavetable voice sequencer and 12-bit mixer
module wave_voice_sequencer #(
  parameter int VOICES = 16,
  parameter int FRAC_W = 10
) (
  input  logic                       CLK,
  input  logic                       RST,
  input  logic                       sample_tick,
  input  logic                       cfg_we,
  input  logic [$clog2(VOICES)-1:0]  cfg_voice,
  input  logic                       cfg_en,
  input  logic [6:0]                 cfg_instr,
  input  logic [9:0]                 cfg_len,
  input  logic [9+FRAC_W:0]          cfg_inc,
  output logic [6:0]                 instrument,
  output logic [9:0]                 pointer,
  input  logic [11:0]                value_in,
  output logic [11:0]                mix_out,
  output logic                       frame_done,
  output logic                       busy,
  output logic                       overrun
);

  localparam int VW    = $clog2(VOICES);
  localparam int ACC_W = 10 + FRAC_W;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ISSUE = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  logic [1:0]       state_q, state_d;
  logic [VW-1:0]    v_q, v_d;
  logic [6:0]       instrument_q, instrument_d;
  logic [9:0]       pointer_q, pointer_d;
  logic [11:0]      sum_q, sum_d, mix_out_q;
  logic             frame_done_q, overrun_q;
  logic             act_p1_q, act_p2_q;

  logic             en_q    [VOICES];
  logic [6:0]       instr_q [VOICES];
  logic [9:0]       len_q   [VOICES];
  logic [ACC_W-1:0] inc_q   [VOICES];
  logic [ACC_W-1:0] acc_q   [VOICES];

  logic             start, last_drain, cur_act, load_instr;
  logic [VW-1:0]    nv;
  logic [ACC_W:0]   sum1, sum2, len_sh;
  logic [10:0]      len_ext;
  logic [ACC_W-1:0] acc_upd;
  logic [7:0]       samp;
  logic [3:0]       unused_value_hi;

  assign instrument      = instrument_q;
  assign pointer         = pointer_q;
  assign mix_out         = mix_out_q;
  assign frame_done      = frame_done_q;
  assign overrun         = overrun_q;
  assign busy            = (state_q != S_IDLE);
  assign unused_value_hi = value_in[11:8];

  assign start      = (state_q == S_IDLE) && sample_tick;
  assign last_drain = (state_q == S_DRAIN) && (v_q == VW'(1));
  assign cur_act    = (state_q == S_ISSUE) && en_q[v_q] && (len_q[v_q] != 10'd0);
  // offset-binary to two's complement: x - 128 is just an MSB flip
  assign samp       = {~value_in[7], value_in[6:0]};

  // frame sequencing: ISSUE walks every voice, DRAIN covers the lookup latency
  always_comb begin
    state_d = state_q;
    v_d     = v_q;
    case (state_q)
      S_IDLE:  if (sample_tick) begin state_d = S_ISSUE; v_d = '0; end
      S_ISSUE: begin
        if (v_q == VW'(VOICES - 1)) begin state_d = S_DRAIN; v_d = '0; end
        else v_d = v_q + 1'b1;
      end
      S_DRAIN: begin
        if (v_q == VW'(1)) state_d = S_DONE;
        else v_d = v_q + 1'b1;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // instrument leads pointer by one cycle, so it is fetched for the next voice to issue
  always_comb begin
    nv           = (state_q == S_IDLE) ? '0 : v_q + 1'b1;
    load_instr   = start || ((state_q == S_ISSUE) && (v_q != VW'(VOICES - 1)));
    instrument_d = 7'd0;
    if (load_instr && en_q[nv] && (len_q[nv] != 10'd0)) instrument_d = instr_q[nv];
    pointer_d    = cur_act ? acc_q[v_q][ACC_W-1:FRAC_W] : 10'd0;
  end

  // phase advance with single subtract, then integer clear if the step still overshoots
  always_comb begin
    len_ext = {1'b0, len_q[v_q]};
    len_sh  = {len_ext, {FRAC_W{1'b0}}};
    sum1    = {1'b0, acc_q[v_q]} + {1'b0, inc_q[v_q]};
    sum2    = sum1 - len_sh;
    acc_upd = sum1[ACC_W-1:0];
    if (sum1[ACC_W:FRAC_W] >= len_ext) begin
      if (sum2[ACC_W:FRAC_W] >= len_ext) acc_upd = {10'd0, sum2[FRAC_W-1:0]};
      else                               acc_upd = sum2[ACC_W-1:0];
    end
  end

  // mix accumulation for the voice whose lookup result is on value_in this cycle
  always_comb begin
    sum_d = sum_q;
    if (act_p2_q) sum_d = sum_q + {{4{samp[7]}}, samp};
  end

  // frame control, lookup outputs and mix registers
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q      <= S_IDLE;
      v_q          <= '0;
      instrument_q <= 7'd0;
      pointer_q    <= 10'd0;
      act_p1_q     <= 1'b0;
      act_p2_q     <= 1'b0;
      sum_q        <= 12'd0;
      mix_out_q    <= 12'd0;
      frame_done_q <= 1'b0;
      overrun_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      v_q          <= v_d;
      instrument_q <= instrument_d;
      pointer_q    <= pointer_d;
      act_p1_q     <= cur_act;
      act_p2_q     <= act_p1_q;
      sum_q        <= start ? 12'd0 : sum_d;
      frame_done_q <= last_drain;
      if (last_drain) mix_out_q <= sum_d;
      if (sample_tick && (state_q != S_IDLE)) overrun_q <= 1'b1;
    end
  end

  // per-voice state; a config write lands after the accumulate so it wins on collision
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      for (int i = 0; i < VOICES; i++) begin
        en_q[i]    <= 1'b0;
        instr_q[i] <= 7'd0;
        len_q[i]   <= 10'd0;
        inc_q[i]   <= '0;
        acc_q[i]   <= '0;
      end
    end else begin
      if (cur_act) acc_q[v_q] <= acc_upd;
      if (cfg_we) begin
        en_q[cfg_voice]    <= cfg_en;
        instr_q[cfg_voice] <= cfg_instr;
        len_q[cfg_voice]   <= cfg_len;
        inc_q[cfg_voice]   <= cfg_inc;
        acc_q[cfg_voice]   <= '0;
      end
    end
  end

endmodule
